// File: rtl/pipeline_pkg.sv
// Shared types and hazard stall-depth constants for the 5-stage pipeline control.
// Stall depths depend on whether the register file bypasses the WB write.
package pipeline_pkg;

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Cycles the ID instruction must wait for a producer in each stage.
  function automatic logic [1:0] ex_stall_depth(input int unsigned wb_bypass);
    return (wb_bypass != 0) ? 2'd2 : 2'd3;
  endfunction

  function automatic logic [1:0] mem_stall_depth(input int unsigned wb_bypass);
    return (wb_bypass != 0) ? 2'd1 : 2'd2;
  endfunction

  function automatic logic [1:0] wb_stall_depth(input int unsigned wb_bypass);
    return (wb_bypass != 0) ? 2'd0 : 2'd1;
  endfunction

endpackage

// File: rtl/raw_hazard_detect.sv
// Combinational RAW detector: returns the number of stall cycles the ID
// instruction needs before its sources are readable (0 = none).
module raw_hazard_detect
  import pipeline_pkg::*;
#(
  parameter int unsigned WB_BYPASS = 1
) (
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic [4:0] ex_write_reg,
  input  logic       ex_reg_write,
  input  logic [4:0] mem_write_reg,
  input  logic       mem_reg_write,
  input  logic [4:0] wb_write_reg,
  input  logic       wb_reg_write,
  output logic [1:0] need_o
);

  localparam logic [1:0] EX_N  = ex_stall_depth(WB_BYPASS);
  localparam logic [1:0] MEM_N = mem_stall_depth(WB_BYPASS);
  localparam logic [1:0] WB_N  = wb_stall_depth(WB_BYPASS);

  logic ex_hit, mem_hit, wb_hit;

  assign ex_hit =
      (id_uses_rs && ex_reg_write && (id_rs == ex_write_reg) && (id_rs != REG_ZERO)) ||
      (id_uses_rt && ex_reg_write && (id_rt == ex_write_reg) && (id_rt != REG_ZERO));
  assign mem_hit =
      (id_uses_rs && mem_reg_write && (id_rs == mem_write_reg) && (id_rs != REG_ZERO)) ||
      (id_uses_rt && mem_reg_write && (id_rt == mem_write_reg) && (id_rt != REG_ZERO));
  assign wb_hit =
      (id_uses_rs && wb_reg_write && (id_rs == wb_write_reg) && (id_rs != REG_ZERO)) ||
      (id_uses_rt && wb_reg_write && (id_rt == wb_write_reg) && (id_rt != REG_ZERO));

  // Depths shrink monotonically with stage age, so priority order yields the max.
  always_comb begin
    need_o = 2'd0;
    if (ex_hit)       need_o = EX_N;
    else if (mem_hit) need_o = MEM_N;
    else if (wb_hit)  need_o = WB_N;
  end

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing: stalls on RAW hazards (no forwarding), squashes the
// three younger instructions on a taken branch, and counts stalls/flushes.
module hazard_stall_controller
  import pipeline_pkg::*;
#(
  parameter int unsigned WB_BYPASS = 1,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [4:0]       ex_write_reg,
  input  logic             ex_reg_write,
  input  logic [4:0]       mem_write_reg,
  input  logic             mem_reg_write,
  input  logic [4:0]       wb_write_reg,
  input  logic             wb_reg_write,
  input  logic             mem_pcsrc,
  output logic             pc_write_en,
  output logic             ifid_write_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  logic [1:0] need;

  raw_hazard_detect #(.WB_BYPASS(WB_BYPASS)) u_detect (
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_uses_rs    (id_uses_rs),
    .id_uses_rt    (id_uses_rt),
    .ex_write_reg  (ex_write_reg),
    .ex_reg_write  (ex_reg_write),
    .mem_write_reg (mem_write_reg),
    .mem_reg_write (mem_reg_write),
    .wb_write_reg  (wb_write_reg),
    .wb_reg_write  (wb_reg_write),
    .need_o        (need)
  );

  state_t           state_q, state_d;
  logic [1:0]       rem_q, rem_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    state_d       = state_q;
    rem_d         = rem_q;
    stall_cnt_d   = stall_cnt_q;
    flush_cnt_d   = flush_cnt_q;
    pc_write_en   = 1'b1;
    ifid_write_en = 1'b1;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    exmem_flush   = 1'b0;
    if (!reset_n) begin
      pc_write_en   = 1'b0;
      ifid_write_en = 1'b0;
      ifid_flush    = 1'b1;
      idex_flush    = 1'b1;
      exmem_flush   = 1'b1;
      state_d       = RUN;
      rem_d         = 2'd0;
      stall_cnt_d   = '0;
      flush_cnt_d   = '0;
    end else if (mem_pcsrc) begin
      // Taken branch wins: the stalled ID instruction is squashed with the rest.
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      state_d     = RUN;
      rem_d       = 2'd0;
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end else if (state_q == STALL) begin
      pc_write_en   = 1'b0;
      ifid_write_en = 1'b0;
      idex_flush    = 1'b1;
      stall_cnt_d   = stall_cnt_q + CNT_W'(1);
      rem_d         = rem_q - 2'd1;
      if (rem_q == 2'd1) state_d = RUN;
    end else if (need != 2'd0) begin
      pc_write_en   = 1'b0;
      ifid_write_en = 1'b0;
      idex_flush    = 1'b1;
      stall_cnt_d   = stall_cnt_q + CNT_W'(1);
      if (need > 2'd1) begin
        state_d = STALL;
        rem_d   = need - 2'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= RUN;
      rem_q       <= 2'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Randomized + directed bench: two controllers (bypass on, 32-bit counters;
// bypass off, 3-bit counters to exercise wrap) against a pending-stall model.
module tb_hazard_stall_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic [4:0] id_rs, id_rt, ex_wr, mem_wr, wb_wr;
  logic       id_urs, id_urt, ex_rw, mem_rw, wb_rw, pcsrc;

  logic        pc1, ifw1, iff1, idf1, exf1;
  logic [31:0] sc1, fc1;
  logic        pc0, ifw0, iff0, idf0, exf0;
  logic [2:0]  sc0, fc0;

  hazard_stall_controller #(.WB_BYPASS(1), .CNT_W(32)) dut1 (
    .clock(clk), .reset_n(reset_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_urs), .id_uses_rt(id_urt), .ex_write_reg(ex_wr), .ex_reg_write(ex_rw),
    .mem_write_reg(mem_wr), .mem_reg_write(mem_rw), .wb_write_reg(wb_wr), .wb_reg_write(wb_rw),
    .mem_pcsrc(pcsrc), .pc_write_en(pc1), .ifid_write_en(ifw1), .ifid_flush(iff1),
    .idex_flush(idf1), .exmem_flush(exf1), .stall_count(sc1), .flush_count(fc1));

  hazard_stall_controller #(.WB_BYPASS(0), .CNT_W(3)) dut0 (
    .clock(clk), .reset_n(reset_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_urs), .id_uses_rt(id_urt), .ex_write_reg(ex_wr), .ex_reg_write(ex_rw),
    .mem_write_reg(mem_wr), .mem_reg_write(mem_rw), .wb_write_reg(wb_wr), .wb_reg_write(wb_rw),
    .mem_pcsrc(pcsrc), .pc_write_en(pc0), .ifid_write_en(ifw0), .ifid_flush(iff0),
    .idex_flush(idf0), .exmem_flush(exf0), .stall_count(sc0), .flush_count(fc0));

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: index 0 = no bypass, 1 = bypass. pend = stall cycles still owed.
  int     pend[2];
  longint m_sc[2], m_fc[2];

  function automatic bit hit(input logic u, input logic [4:0] s, input logic rw, input logic [4:0] d);
    return u && rw && (s == d) && (s != 5'd0);
  endfunction

  function automatic int need(input int b);
    int n = 0;
    if ((hit(id_urs, id_rs, wb_rw, wb_wr) || hit(id_urt, id_rt, wb_rw, wb_wr)) && (1 - b) > n)
      n = 1 - b;
    if ((hit(id_urs, id_rs, mem_rw, mem_wr) || hit(id_urt, id_rt, mem_rw, mem_wr)) && (2 - b) > n)
      n = 2 - b;
    if ((hit(id_urs, id_rs, ex_rw, ex_wr) || hit(id_urt, id_rt, ex_rw, ex_wr)) && (3 - b) > n)
      n = 3 - b;
    return n;
  endfunction

  // {pc_write_en, ifid_write_en, ifid_flush, idex_flush, exmem_flush}
  function automatic logic [4:0] exp_out(input int b);
    if (!reset_n) return 5'b00111;
    if (pcsrc) return 5'b11111;
    if (pend[b] > 0 || need(b) > 0) return 5'b00010;
    return 5'b11000;
  endfunction

  task automatic model_edge(input int b);
    int n;
    if (!reset_n) begin
      pend[b] = 0; m_sc[b] = 0; m_fc[b] = 0;
    end else if (pcsrc) begin
      pend[b] = 0; m_fc[b]++;
    end else if (pend[b] > 0) begin
      pend[b]--; m_sc[b]++;
    end else begin
      n = need(b);
      if (n > 0) begin
        m_sc[b]++; pend[b] = n - 1;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
    chk("outs_byp1", 64'({pc1, ifw1, iff1, idf1, exf1}), 64'(exp_out(1)));
    chk("outs_byp0", 64'({pc0, ifw0, iff0, idf0, exf0}), 64'(exp_out(0)));
    @(posedge clk);
    model_edge(1);
    model_edge(0);
    #1;
    chk("stall_cnt1", 64'(sc1), 64'(m_sc[1] & 64'hffff_ffff));
    chk("flush_cnt1", 64'(fc1), 64'(m_fc[1] & 64'hffff_ffff));
    chk("stall_cnt0", 64'(sc0), 64'(m_sc[0] & 64'h7));
    chk("flush_cnt0", 64'(fc0), 64'(m_fc[0] & 64'h7));
  endtask

  task automatic clr();
    id_rs = '0; id_rt = '0; ex_wr = '0; mem_wr = '0; wb_wr = '0;
    id_urs = 0; id_urt = 0; ex_rw = 0; mem_rw = 0; wb_rw = 0; pcsrc = 0;
  endtask

  initial begin
    for (int b = 0; b < 2; b++) begin
      pend[b] = 0; m_sc[b] = 0; m_fc[b] = 0;
    end
    clr();
    // Reset with a branch and an EX hazard present.
    reset_n = 0; pcsrc = 1; id_rs = 5'd3; id_urs = 1; ex_wr = 5'd3; ex_rw = 1;
    step(); step();
    reset_n = 1; clr();

    // EX RAW on $2: 2 stalls with bypass, 3 without.
    id_rs = 5'd2; id_urs = 1; ex_wr = 5'd2; ex_rw = 1;
    step(); clr(); step(); step(); step();
    chk("ex_raw_stalls_byp1", 64'(sc1), 64'd2);
    chk("ex_raw_stalls_byp0", 64'(sc0), 64'd3);

    // MEM RAW on rt.
    id_rt = 5'd5; id_urt = 1; mem_wr = 5'd5; mem_rw = 1;
    step(); clr(); step(); step();
    // WB RAW on rs.
    id_rs = 5'd7; id_urs = 1; wb_wr = 5'd7; wb_rw = 1;
    step(); clr(); step();

    // $0 and disabled matches never stall.
    id_urs = 1; ex_rw = 1; step();
    clr(); id_rt = 5'd9; ex_wr = 5'd9; ex_rw = 1; step();
    clr(); id_rs = 5'd4; id_urs = 1; ex_wr = 5'd4; step();

    // Branch in RUN.
    clr(); pcsrc = 1; step();
    chk("branch_flushes1", 64'(fc1), 64'd1);
    clr(); step();

    // Branch on the 2nd cycle of a 3-cycle stall (no-bypass EX hazard).
    id_rs = 5'd6; id_urs = 1; ex_wr = 5'd6; ex_rw = 1;
    step(); clr(); pcsrc = 1; step(); clr(); step(); step();

    // Randomized traffic with a small register range to make matches common.
    for (int i = 0; i < 600; i++) begin
      id_rs  = 5'($urandom_range(0, 3));
      id_rt  = 5'($urandom_range(0, 3));
      ex_wr  = 5'($urandom_range(0, 3));
      mem_wr = 5'($urandom_range(0, 3));
      wb_wr  = 5'($urandom_range(0, 3));
      id_urs = 1'($urandom);
      id_urt = 1'($urandom);
      ex_rw  = 1'($urandom);
      mem_rw = 1'($urandom);
      wb_rw  = 1'($urandom);
      pcsrc  = ($urandom_range(0, 9) == 0);
      reset_n = ($urandom_range(0, 79) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Sequences the 5-stage pipeline: generates PC/IF-ID write enables and IF-ID, ID-EX, EX-MEM flush (bubble) controls.
- Resolves RAW data hazards by stalling. The datapath has no forwarding.
- Resolves taken branches, decided in MEM via PCSrc, by squashing the three younger instructions.
- Keeps stall and flush performance counters. Sits at top level beside the stage registers.

Parameters:
- WB_BYPASS, 1: 1 = register file returns the value being written in WB during the same cycle; 0 = it does not, so one extra stall cycle is needed.
- CNT_W, 32: width of the performance counters.

Ports:
- clock  in  1  pipeline clock; all state updates on rising edge
- reset_n  in  1  synchronous, active-low reset
- id_rs  in  5  rs field of instruction_ID
- id_rt  in  5  rt field of instruction_ID
- id_uses_rs  in  1  ID instruction reads rs
- id_uses_rt  in  1  ID instruction reads rt
- ex_write_reg  in  5  destination register of the instruction in EX (post-RegDst mux)
- ex_reg_write  in  1  RegWrite_EX
- mem_write_reg  in  5  RegisterRd_MEM
- mem_reg_write  in  1  RegWrite_MEM
- wb_write_reg  in  5  RegisterRd_WB
- wb_reg_write  in  1  RegWrite_WB
- mem_pcsrc  in  1  taken branch resolved in MEM (PCSrc)
- pc_write_en  out  1  PC may update
- ifid_write_en  out  1  IF/ID may load
- ifid_flush  out  1  IF/ID loads NOP
- idex_flush  out  1  ID/EX loads bubble (all control bits 0)
- exmem_flush  out  1  EX/MEM loads bubble
- stall_count  out  CNT_W  cycles spent stalled
- flush_count  out  CNT_W  taken-branch flush events

Behaviour:
- Reset:
  - While reset_n=0 at an edge: state=RUN, remaining=0, both counters=0.
  - Outputs are combinational on reset_n. While reset_n=0: pc_write_en=0, ifid_write_en=0, all three flushes=1.
- Match rule: a source matches a stage if its uses_* bit is 1, the stage's reg_write is 1, and the registers are equal and nonzero. Register 0 never matches.
- Required stall cycles N per match: EX match = 2+(1-WB_BYPASS); MEM match = 1+(1-WB_BYPASS); WB match = 1-WB_BYPASS. N = max over all matches; N=0 when there are no matches.
- States: RUN, STALL. 2-bit down-counter `remaining`.
- RUN, mem_pcsrc=0, N=0:
  - Outputs: enables=1, flushes=0.
- RUN, mem_pcsrc=0, N>0:
  - Stall this cycle: pc_write_en=0, ifid_write_en=0, idex_flush=1. Other flushes 0.
  - stall_count+1.
  - If N>1: next state STALL with remaining=N-1. Otherwise stay in RUN.
- STALL, mem_pcsrc=0:
  - Same stall outputs as above; stall_count+1.
  - remaining decrements.
  - When remaining=1 at the edge, next state is RUN.
  - Hazard inputs are ignored in STALL.
- mem_pcsrc=1, any state (highest priority):
  - Outputs: pc_write_en=1 (PC loads branch target), ifid_write_en=1, ifid_flush=idex_flush=exmem_flush=1.
  - Next state RUN, remaining=0, flush_count+1.
  - The cycle is not counted as a stall. Any hazard in ID is discarded because that instruction is squashed.
- RUN re-evaluates hazards every cycle. Back-to-back hazards re-enter the stall without a gap.
- Counters wrap modulo 2^CNT_W.
- Outputs are combinational from state and inputs, with no added latency. They must be stable before the edge they control.

Decomposition:
- Shared package `pipeline_pkg`: state enum {RUN, STALL}; REG_ZERO=5'd0; the stall-depth constants for EX/MEM/WB matches as functions of WB_BYPASS.
- One natural sub-module, `raw_hazard_detect`: purely combinational; takes the source and destination fields and returns N.
- The FSM, counter and performance counters stay in the top module.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with mem_pcsrc=1 and a hazard present -> all flushes=1, enables=0, both counters read 0 after release.
- EX RAW, WB_BYPASS=1:
  - Stimulus: lw $2 in EX, add using $2 in ID (id_rs=2, ex_write_reg=2, ex_reg_write=1).
  - Required: pc_write_en=0 for exactly 2 cycles, idex_flush=1 in both, then RUN; stall_count=2.
- MEM RAW, WB_BYPASS=0 -> 2 stall cycles. WB RAW, WB_BYPASS=0 -> 1 stall cycle. WB RAW, WB_BYPASS=1 -> 0 stall cycles.
- $0 and disabled cases:
  - id_rs=0 with ex_write_reg=0 -> no stall.
  - id_uses_rt=0 with an rt match -> no stall.
  - ex_reg_write=0 with a match -> no stall.
- Branch: mem_pcsrc=1 for 1 cycle in RUN -> all three flushes=1, pc_write_en=1, flush_count=1.
- Branch mid-stall: mem_pcsrc=1 on the 2nd cycle of a 3-cycle stall -> flush outputs that cycle, state RUN next cycle, stall_count=1, flush_count=1.
